// File: rtl/alu_exec_unit.sv
// EX-stage ALU with a 1-entry valid/ready output register.
// Optional signed-overflow flag for ADD/SUB built only when ALU_OVF_TRAP_EN is defined.
module alu_exec_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_OP    = 4,
    parameter int NB_SHAMT = 5
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [NB_OP-1:0]    i_operation,
    input  logic [NB_DATA-1:0]  i_data_a,
    input  logic [NB_DATA-1:0]  i_data_b,
    input  logic [NB_SHAMT-1:0] i_shamt,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [NB_DATA-1:0]  o_result,
    output logic                o_zero,
    output logic                o_ovf
);
    localparam logic [NB_OP-1:0] OP_ADD  = 4'h0;
    localparam logic [NB_OP-1:0] OP_SUB  = 4'h1;
    localparam logic [NB_OP-1:0] OP_AND  = 4'h2;
    localparam logic [NB_OP-1:0] OP_OR   = 4'h3;
    localparam logic [NB_OP-1:0] OP_XOR  = 4'h4;
    localparam logic [NB_OP-1:0] OP_NOR  = 4'h5;
    localparam logic [NB_OP-1:0] OP_SLT  = 4'h6;
    localparam logic [NB_OP-1:0] OP_SLL  = 4'h7;
    localparam logic [NB_OP-1:0] OP_SRL  = 4'h8;
    localparam logic [NB_OP-1:0] OP_SRA  = 4'h9;
    localparam logic [NB_OP-1:0] OP_SLLV = 4'hA;
    localparam logic [NB_OP-1:0] OP_SRLV = 4'hB;
    localparam logic [NB_OP-1:0] OP_SRAV = 4'hC;
    localparam logic [NB_OP-1:0] OP_ADDU = 4'hD;
    localparam logic [NB_OP-1:0] OP_SUBU = 4'hE;
    localparam int HALF = NB_DATA / 2;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state_reg;
    logic [NB_DATA-1:0]  result_reg;
    logic                zero_reg;
    logic [NB_DATA-1:0]  result_next;
    logic [NB_DATA-1:0]  add_res;
    logic [NB_DATA-1:0]  sub_res;
    logic [NB_SHAMT-1:0] sh_fix;
    logic [NB_SHAMT-1:0] sh_var;
    logic                accept;

    assign o_valid  = (state_reg == FULL);
    assign o_ready  = (state_reg == EMPTY) | i_ready;
    assign accept   = i_valid & o_ready;
    assign o_result = result_reg;
    assign o_zero   = zero_reg;

    assign add_res = i_data_a + i_data_b;
    assign sub_res = i_data_a - i_data_b;
    assign sh_fix  = i_shamt;
    assign sh_var  = i_data_a[NB_SHAMT-1:0];

    always_comb begin
        result_next = '0;
        case (i_operation)
            OP_ADD, OP_ADDU: result_next = add_res;
            OP_SUB, OP_SUBU: result_next = sub_res;
            OP_AND:  result_next = i_data_a & i_data_b;
            OP_OR:   result_next = i_data_a | i_data_b;
            OP_XOR:  result_next = i_data_a ^ i_data_b;
            OP_NOR:  result_next = ~(i_data_a | i_data_b);
            OP_SLT:  result_next = {{(NB_DATA-1){1'b0}}, ($signed(i_data_a) < $signed(i_data_b))};
            OP_SLL:  result_next = i_data_b << sh_fix;
            OP_SRL:  result_next = i_data_b >> sh_fix;
            OP_SRA:  result_next = $unsigned($signed(i_data_b) >>> sh_fix);
            OP_SLLV: result_next = i_data_b << sh_var;
            OP_SRLV: result_next = i_data_b >> sh_var;
            OP_SRAV: result_next = $unsigned($signed(i_data_b) >>> sh_var);
            default: result_next = {i_data_b[HALF-1:0], {HALF{1'b0}}};
        endcase
    end

`ifdef ALU_OVF_TRAP_EN
    logic ovf_reg;
    logic ovf_next;

    // Only the signed variants trap; the unsigned twins share the datapath but never flag.
    always_comb begin
        ovf_next = 1'b0;
        if (i_operation == OP_ADD)
            ovf_next = (i_data_a[NB_DATA-1] == i_data_b[NB_DATA-1]) &&
                       (add_res[NB_DATA-1] != i_data_a[NB_DATA-1]);
        else if (i_operation == OP_SUB)
            ovf_next = (i_data_a[NB_DATA-1] != i_data_b[NB_DATA-1]) &&
                       (sub_res[NB_DATA-1] != i_data_a[NB_DATA-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            ovf_reg <= 1'b0;
        else if (accept)
            ovf_reg <= ovf_next;
    end

    assign o_ovf = ovf_reg;
`else
    assign o_ovf = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg  <= EMPTY;
            result_reg <= '0;
            zero_reg   <= 1'b0;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_reg  <= FULL;
                        result_reg <= result_next;
                        zero_reg   <= (result_next == '0);
                    end
                end
                default: begin
                    // A drain and a fresh accept in the same cycle keep the register full.
                    if (accept) begin
                        result_reg <= result_next;
                        zero_reg   <= (result_next == '0);
                    end else if (i_ready) begin
                        state_reg <= EMPTY;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit: reset, op table, reset mid-transfer and backpressure.
// Expected o_ovf follows ALU_OVF_TRAP_EN.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [3:0]  operation;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        in_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_unit dut (
        .i_clk(clk), .i_reset(reset), .i_valid(in_valid), .o_ready(out_ready),
        .i_operation(operation), .i_data_a(data_a), .i_data_b(data_b), .i_shamt(shamt),
        .o_valid(out_valid), .i_ready(in_ready), .o_result(result), .o_zero(zero), .o_ovf(ovf)
    );

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        ovf_trap;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];

`ifdef ALU_OVF_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        in_valid  = 1'b1;
        operation = op;
        data_a    = a;
        data_b    = b;
        shamt     = sh;
    endtask

    initial begin
        vecs[0]  = '{4'h0, 32'd5,         32'd7,         5'd0,  32'd12,        1'b0};
        vecs[1]  = '{4'h1, 32'd3,         32'd3,         5'd0,  32'd0,         1'b0};
        vecs[2]  = '{4'h2, 32'hF0F0_00FF, 32'h0FF0_0F0F, 5'd0,  32'h00F0_000F, 1'b0};
        vecs[3]  = '{4'h3, 32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F, 1'b0};
        vecs[4]  = '{4'h4, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 1'b0};
        vecs[5]  = '{4'h5, 32'h0000_0000, 32'h0000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[6]  = '{4'h6, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd1,         1'b0};
        vecs[7]  = '{4'h6, 32'd1,         32'hFFFF_FFFF, 5'd0,  32'd0,         1'b0};
        vecs[8]  = '{4'h7, 32'd3,         32'd1,         5'd31, 32'h8000_0000, 1'b0};
        vecs[9]  = '{4'h8, 32'd1,         32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0};
        vecs[10] = '{4'h9, 32'd3,         32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0};
        vecs[11] = '{4'hA, 32'h0000_0024, 32'd3,         5'd9,  32'h0000_0030, 1'b0};
        vecs[12] = '{4'hB, 32'd4,         32'h8000_0000, 5'd1,  32'h0800_0000, 1'b0};
        vecs[13] = '{4'hC, 32'd31,        32'h8000_0000, 5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[14] = '{4'hD, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'd0,         1'b0};
        vecs[15] = '{4'hE, 32'd0,         32'd1,         5'd0,  32'hFFFF_FFFF, 1'b0};
        vecs[16] = '{4'hF, 32'hDEAD_BEEF, 32'h0000_1234, 5'd0,  32'h1234_0000, 1'b0};
        vecs[17] = '{4'h0, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b1};
        vecs[18] = '{4'hD, 32'h7FFF_FFFF, 32'd1,         5'd0,  32'h8000_0000, 1'b0};
        vecs[19] = '{4'h1, 32'h8000_0000, 32'd1,         5'd0,  32'h7FFF_FFFF, 1'b1};
        vecs[20] = '{4'h1, 32'd0,         32'h8000_0000, 5'd0,  32'h8000_0000, 1'b1};

        reset = 1'b1; in_valid = 1'b0; in_ready = 1'b0;
        operation = '0; data_a = '0; data_b = '0; shamt = '0;
        step(); step();
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_zero", {31'd0, zero}, 32'd0);
        check("reset_ovf", {31'd0, ovf}, 32'd0);
        check("reset_ready", {31'd0, out_ready}, 32'd1);
        reset = 1'b0;

        // Reset while FULL and stalled
        drive(4'h0, 32'd5, 32'd7, 5'd0);
        step();
        in_valid = 1'b0;
        check("rst_mid_valid", {31'd0, out_valid}, 32'd1);
        check("rst_mid_ready", {31'd0, out_ready}, 32'd0);
        check("rst_mid_result", result, 32'd12);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_mid_after_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_after_result", result, 32'd0);

        // Op table, streaming with downstream always ready
        in_ready = 1'b1;
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
            step();
            check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
            check($sformatf("vec%0d_result", i), result, vecs[i].res);
            check($sformatf("vec%0d_zero", i), {31'd0, zero}, {31'd0, vecs[i].res == 32'd0});
            check($sformatf("vec%0d_ovf", i), {31'd0, ovf}, {31'd0, vecs[i].ovf_trap & TRAP});
            $display("vec %0d op=%0h a=%08h b=%08h sh=%0d -> res=%08h zero=%0b ovf=%0b",
                     i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, result, zero, ovf);
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: two back-to-back accepts, then stall with a third pending
        drive(4'h0, 32'd1, 32'd2, 5'd0);
        step();
        check("bp_first", result, 32'd3);
        drive(4'h0, 32'd10, 32'd20, 5'd0);
        step();
        check("bp_second", result, 32'd30);
        in_ready = 1'b0;
        drive(4'h0, 32'd100, 32'd200, 5'd0);
        #1;
        check("bp_ready_low", {31'd0, out_ready}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("bp_hold%0d_result", c), result, 32'd30);
            check($sformatf("bp_hold%0d_ready", c), {31'd0, out_ready}, 32'd0);
            check($sformatf("bp_hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
        end
        in_ready = 1'b1;
        #1;
        check("bp_ready_release", {31'd0, out_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_third_valid", {31'd0, out_valid}, 32'd1);
        check("bp_third_result", result, 32'd300);
        step();
        check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
        check("bp_empty_result", result, 32'd300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
